// File: rtl/axil_slave_regfile_if.sv
// rtl/axil_slave_regfile_if.sv - AXI-Lite bus defaults and the slave-port interface
package axil_pkg;
  parameter int AXIL_ADDR_WIDTH = 32;
  parameter int AXIL_DATA_WIDTH = 32;
  parameter logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  parameter logic [1:0] AXIL_RESP_SLVERR = 2'b10;
endpackage

interface axil_slave_regfile_if #(
  parameter int AXI_ADDR_WIDTH = axil_pkg::AXIL_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH = axil_pkg::AXIL_DATA_WIDTH
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI-Lite register bank with byte strobes and per-register write pulses
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = AXIL_ADDR_WIDTH,
  parameter int                        AXI_DATA_WIDTH = AXIL_DATA_WIDTH,
  parameter int                        NUM_REGS       = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axil_slave_regfile_if.slave       s_axil,
  output logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS],
  output logic [NUM_REGS-1:0]       wr_pulse
);

  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_WIDTH-1:0] NUM_REGS_A = AXI_ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // Addresses below the base wrap to huge offsets, so both bounds are checked explicitly.
  function automatic logic addr_hit(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> LANE_BITS) < NUM_REGS_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off[LANE_BITS +: IDX_W];
  endfunction

  wr_state_t                 wr_state;
  logic                      aw_ready_q;
  logic                      w_ready_q;
  logic                      b_valid_q;
  logic [1:0]                b_resp_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;

  rd_state_t                 rd_state;
  logic                      ar_ready_q;
  logic                      r_valid_q;
  logic [1:0]                r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic                      commit;
  logic [AXI_ADDR_WIDTH-1:0] c_addr;
  logic [AXI_DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]         c_strb;
  logic                      c_hit;
  logic [IDX_W-1:0]          c_idx;

  assign aw_hs = s_axil.awvalid & aw_ready_q;
  assign w_hs  = s_axil.wvalid  & w_ready_q;
  assign ar_hs = s_axil.arvalid & ar_ready_q;

  assign s_axil.awready = aw_ready_q;
  assign s_axil.wready  = w_ready_q;
  assign s_axil.bvalid  = b_valid_q;
  assign s_axil.bresp   = b_resp_q;
  assign s_axil.arready = ar_ready_q;
  assign s_axil.rvalid  = r_valid_q;
  assign s_axil.rresp   = r_resp_q;
  assign s_axil.rdata   = r_data_q;

  // Whichever half arrived first comes from the latch, the other straight off the bus.
  always_comb begin
    c_addr = (wr_state == WR_HAVE_AW) ? aw_addr_q : s_axil.awaddr;
    c_data = (wr_state == WR_HAVE_W)  ? w_data_q  : s_axil.wdata;
    c_strb = (wr_state == WR_HAVE_W)  ? w_strb_q  : s_axil.wstrb;
    commit = 1'b0;
    case (wr_state)
      WR_IDLE:    commit = aw_hs & w_hs;
      WR_HAVE_AW: commit = w_hs;
      WR_HAVE_W:  commit = aw_hs;
      default:    commit = 1'b0;
    endcase
    c_hit = addr_hit(c_addr);
    c_idx = addr_idx(c_addr);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state   <= WR_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= AXIL_RESP_OKAY;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_pulse   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        wr_state   <= WR_RESP;
        aw_ready_q <= 1'b0;
        w_ready_q  <= 1'b0;
        b_valid_q  <= 1'b1;
        b_resp_q   <= c_hit ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        if (c_hit) begin
          wr_pulse[c_idx] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (c_strb[b]) begin
              regs_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
          end
        end
      end else begin
        case (wr_state)
          WR_IDLE: begin
            if (aw_hs) begin
              aw_addr_q  <= s_axil.awaddr;
              wr_state   <= WR_HAVE_AW;
              aw_ready_q <= 1'b0;
              w_ready_q  <= 1'b1;
            end else if (w_hs) begin
              w_data_q   <= s_axil.wdata;
              w_strb_q   <= s_axil.wstrb;
              wr_state   <= WR_HAVE_W;
              aw_ready_q <= 1'b1;
              w_ready_q  <= 1'b0;
            end else begin
              aw_ready_q <= 1'b1;
              w_ready_q  <= 1'b1;
            end
          end
          WR_HAVE_AW, WR_HAVE_W: begin
          end
          WR_RESP: begin
            if (s_axil.bready) begin
              b_valid_q  <= 1'b0;
              wr_state   <= WR_IDLE;
              aw_ready_q <= 1'b1;
              w_ready_q  <= 1'b1;
            end
          end
          default: wr_state <= WR_IDLE;
        endcase
      end
    end
  end

  // regs_q is sampled before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state   <= RD_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= AXIL_RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state   <= RD_RESP;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            if (addr_hit(s_axil.araddr)) begin
              r_data_q <= regs_q[addr_idx(s_axil.araddr)];
              r_resp_q <= AXIL_RESP_OKAY;
            end else begin
              r_data_q <= '0;
              r_resp_q <= AXIL_RESP_SLVERR;
            end
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axil.rready) begin
            rd_state   <= RD_IDLE;
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - scoreboard bench for axil_slave_regfile
module tb_axil_slave_regfile;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h100;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axil_slave_regfile_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();
  logic [DW-1:0] regs_q [NR];
  logic [NR-1:0] wr_pulse;

  axil_slave_regfile #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .NUM_REGS      (NR),
    .BASE_ADDR     (BASE)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axil  (bus),
    .regs_q  (regs_q),
    .wr_pulse(wr_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] regs_or();
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < NR; i++) acc |= regs_q[i];
    return acc;
  endfunction

  // Monitor: pops an expectation whenever a response handshake is about to happen.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got bresp %b with no expected response", bus.bresp);
        end else begin
          check("bresp", 64'(bus.bresp), 64'(bq.pop_front()));
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got rdata %h with no expected response", bus.rdata);
        end else begin
          logic [33:0] e;
          e = rq.pop_front();
          check("rdata", 64'(bus.rdata), 64'(e[31:0]));
          check("rresp", 64'(bus.rresp), 64'(e[33:32]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input bit do_aw, input logic [31:0] awa,
                      input bit do_w, input logic [31:0] wd, input logic [3:0] ws,
                      input bit do_ar, input logic [31:0] ara);
    bit aw_go, w_go, ar_go;
    int k;
    if (do_aw) begin bus.awaddr = awa; bus.awvalid = 1'b1; end
    if (do_w)  begin bus.wdata = wd; bus.wstrb = ws; bus.wvalid = 1'b1; end
    if (do_ar) begin bus.araddr = ara; bus.arvalid = 1'b1; end
    k = 0;
    while ((bus.awvalid || bus.wvalid || bus.arvalid) && k < 20) begin
      @(negedge aclk);
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid  && bus.wready;
      ar_go = bus.arvalid && bus.arready;
      @(posedge aclk);
      #1;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
      if (ar_go) bus.arvalid = 1'b0;
      k++;
    end
    if (bus.awvalid || bus.wvalid || bus.arvalid) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout: valids %b still pending", {bus.awvalid, bus.wvalid, bus.arvalid});
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    bit idle;
    k = 0;
    idle = 1'b0;
    while (!idle && k < 20) begin
      @(negedge aclk);
      idle = bus.awready && bus.wready && bus.arready && !bus.bvalid && !bus.rvalid;
      k++;
    end
    if (!idle) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got aw/w/ar/b/r %b required 11100",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] snap [NR];
    int diffs;
    logic [DW-1:0] r_hold;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_flags", 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 64'h0);
    check("rst_resp_data", 64'({bus.bresp, bus.rresp, bus.rdata}), 64'h0);
    check("rst_regs", 64'(regs_or()), 64'h0);
    check("rst_pulse", 64'(wr_pulse), 64'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rdy_after_release", 64'({bus.awready, bus.wready, bus.arready}), 64'h0);
    @(posedge aclk);
    #1;
    check("rdy_one_cycle", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);

    // Full write, same-cycle AW/W, then read-back
    bq.push_back(2'b00);
    xfer(1'b1, BASE + 32'h8, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, '0);
    check("wr_bvalid_t", 64'({bus.bvalid, bus.awready, bus.wready}), 64'h4);
    check("wr_pulse_2", 64'(wr_pulse), 64'h0004);
    check("wr_reg2", 64'(regs_q[2]), 64'hDEADBEEF);
    @(posedge aclk);
    #1;
    check("wr_done_t1", 64'({bus.bvalid, bus.awready, bus.wready}), 64'h3);
    check("wr_pulse_clear", 64'(wr_pulse), 64'h0);
    rq.push_back({2'b00, 32'hDEADBEEF});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + 32'h8);
    check("rd_rvalid_t", 64'({bus.rvalid, bus.arready}), 64'h2);
    @(posedge aclk);
    #1;
    check("rd_done_t1", 64'({bus.rvalid, bus.arready}), 64'h1);

    // Partial strobe, W three cycles ahead of AW
    bq.push_back(2'b00);
    xfer(1'b1, BASE + 32'hC, 1'b1, 32'hAAAAAAAA, 4'hF, 1'b0, '0);
    wait_idle();
    bq.push_back(2'b00);
    xfer(1'b0, '0, 1'b1, 32'h11223344, 4'b0101, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      check("skew_wait", 64'({bus.awready, bus.wready, bus.bvalid}), 64'h4);
      @(posedge aclk);
      #1;
    end
    xfer(1'b1, BASE + 32'hC, 1'b0, '0, '0, 1'b0, '0);
    check("skew_bvalid", 64'(bus.bvalid), 64'h1);
    check("skew_reg3", 64'(regs_q[3]), 64'hAA22AA44);
    check("skew_pulse", 64'(wr_pulse), 64'h0008);
    wait_idle();
    rq.push_back({2'b00, 32'hAA22AA44});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + 32'hC);
    wait_idle();

    // Out of range write and reads; low lane bits ignored
    for (int i = 0; i < NR; i++) snap[i] = regs_q[i];
    bq.push_back(2'b10);
    xfer(1'b1, BASE + NR * 4, 1'b1, 32'h55555555, 4'hF, 1'b0, '0);
    check("oor_bvalid", 64'(bus.bvalid), 64'h1);
    check("oor_no_pulse", 64'(wr_pulse), 64'h0);
    wait_idle();
    diffs = 0;
    for (int i = 0; i < NR; i++) if (regs_q[i] !== snap[i]) diffs++;
    check("oor_regs_unchanged", 64'(diffs), 64'h0);
    rq.push_back({2'b10, 32'h0});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + NR * 4);
    wait_idle();
    rq.push_back({2'b10, 32'h0});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE - 32'h4);
    wait_idle();
    rq.push_back({2'b00, 32'hDEADBEEF});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + 32'hB);
    wait_idle();

    // Backpressure on both response channels
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'hDEADBEEF});
    xfer(1'b1, BASE + 32'h10, 1'b1, 32'h12345678, 4'hF, 1'b1, BASE + 32'h8);
    r_hold = bus.rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk);
      #1;
      check("bp_flags", 64'({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}), 64'h18);
      check("bp_payload", 64'({bus.bresp, bus.rresp, bus.rdata}), 64'({4'b0000, r_hold}));
    end
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(posedge aclk);
    #1;
    check("bp_release", 64'({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}), 64'h07);
    check("bp_reg4", 64'(regs_q[4]), 64'h12345678);

    // Read/write collision on register 1
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h0});
    xfer(1'b1, BASE + 32'h4, 1'b1, 32'h0BADF00D, 4'hF, 1'b1, BASE + 32'h4);
    check("col_reg1", 64'(regs_q[1]), 64'h0BADF00D);
    wait_idle();
    rq.push_back({2'b00, 32'h0BADF00D});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + 32'h4);
    wait_idle();

    // Reset while a write response is pending
    bus.bready = 1'b0;
    xfer(1'b1, BASE + 32'h14, 1'b1, 32'hCAFE0001, 4'hF, 1'b0, '0);
    check("mrst_bvalid_before", 64'(bus.bvalid), 64'h1);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("mrst_flags", 64'({bus.bvalid, bus.awready, bus.wready, bus.arready}), 64'h0);
    check("mrst_regs", 64'(regs_or()), 64'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    bus.bready = 1'b1;
    wait_idle();
    rq.push_back({2'b00, 32'h0});
    xfer(1'b0, '0, 1'b0, '0, '0, 1'b1, BASE + 32'h8);
    wait_idle();

    check("bq_drained", 64'(bq.size()), 64'h0);
    check("rq_drained", 64'(rq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_slave_regfile.md
# axil_slave_regfile

AXI-Lite responder that terminates one slave port of the AXI-Lite interconnect in a bank of software-visible registers. It accepts independent read and write transactions and applies byte strobes to writes. Addresses outside the bank get SLVERR. It exports register contents and per-register write strobes to local logic, and is the standard endpoint behind each `s_axil_*` slave port.

## Interface
- `AXI_ADDR_WIDTH`, default from `axil_pkg`: address width.
- `AXI_DATA_WIDTH`, default from `axil_pkg`: data width, 32 or 64.
- `NUM_REGS`, default 16: number of registers, ≥2.
- `BASE_ADDR`, default 0: byte address of register 0, aligned to `NUM_REGS*AXI_DATA_WIDTH/8`.
- `aclk` in 1: single clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_axil_awaddr` in AXI_ADDR_WIDTH: write address.
- `s_axil_awvalid` in 1, `s_axil_awready` out 1: AW handshake.
- `s_axil_wdata` in AXI_DATA_WIDTH: write data.
- `s_axil_wstrb` in AXI_DATA_WIDTH/8: byte enables.
- `s_axil_wvalid` in 1, `s_axil_wready` out 1: W handshake.
- `s_axil_bresp` out 2: write response.
- `s_axil_bvalid` out 1, `s_axil_bready` in 1: B handshake.
- `s_axil_araddr` in AXI_ADDR_WIDTH: read address.
- `s_axil_arvalid` in 1, `s_axil_arready` out 1: AR handshake.
- `s_axil_rdata` out AXI_DATA_WIDTH: read data.
- `s_axil_rresp` out 2: read response.
- `s_axil_rvalid` out 1, `s_axil_rready` in 1: R handshake.
- `regs_q` out AXI_DATA_WIDTH [NUM_REGS]: current register contents.
- `wr_pulse` out NUM_REGS: one-cycle strobe per register, high when that register is written.

## Operation
**Address decode**
- Offset = addr − BASE_ADDR.
- Index = offset >> log2(AXI_DATA_WIDTH/8). Low byte-lane bits are ignored.
- In range when 0 ≤ offset and index < NUM_REGS. Response is OKAY (2'b00).
- Otherwise SLVERR (2'b10). No register changes, and read data is 0.

**Write FSM** (states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP)
- WR_IDLE: awready=1, wready=1.
  - AW and W handshake in the same cycle → WR_RESP.
  - AW only → WR_HAVE_AW, address latched.
  - W only → WR_HAVE_W, data and strobe latched.
- WR_HAVE_AW: awready=0, wready=1. W handshake → WR_RESP.
- WR_HAVE_W: awready=1, wready=0. AW handshake → WR_RESP.
- On the transition into WR_RESP, the write commits: each byte with wstrb=1 is updated, and `wr_pulse[index]` pulses for one cycle. Both happen only if the address is in range.
- WR_RESP: bvalid=1, awready=0, wready=0. bresp is held stable. bready → WR_IDLE.

**Read FSM** (states RD_IDLE, RD_RESP)
- RD_IDLE: arready=1. AR handshake → RD_RESP. rdata and rresp are registered from the register contents present at the handshake edge.
- RD_RESP: arready=0, rvalid=1. rdata and rresp are held stable. rready → RD_IDLE.

**Concurrency**
- Read and write paths are fully independent and may be active in the same cycle.
- A read handshaking on the same edge as a write commit to the same register returns the old value.

**Reset**
- Reset is asynchronous.
- All registers, `regs_q`, and `wr_pulse` reset to 0.
- All ready, valid, resp, and rdata outputs reset to 0. Both FSMs go to idle.
- awready, wready, and arready are registered. They rise on the first aclk edge after aresetn deasserts.
- Reset asserted mid-transaction abandons it: no response is issued and no partial write occurs.

## Timing
- Write with AW and W in the same cycle: handshake at edge T. `regs_q` updates and bvalid=1 after edge T. With bready=1, ready is back after edge T+1. Throughput is one write per 2 cycles.
- Write with W one cycle after AW: bvalid rises one cycle later than the same-cycle case.
- Read: handshake at edge T, rvalid=1 after T. With rready held high, arready=1 after T+1, so read throughput is one read per 2 cycles.
- With bready or rready held low, the response holds indefinitely and no new address is accepted on that path.
- `wr_pulse` is high exactly one cycle, aligned with the `regs_q` update.

## Test plan
- **Reset:** reset with traffic idle → all outputs 0. Readies rise 1 cycle after release.
- **Full write, then read-back:** write 0xDEADBEEF, wstrb=4'hF, to BASE+0x8 with AW and W in the same cycle → bresp=00. bvalid appears 1 cycle after handshake, `wr_pulse[2]` is one cycle, `regs_q[2]`=0xDEADBEEF. Read BASE+0x8 → rdata=0xDEADBEEF, rresp=00.
- **Partial strobe, skewed channels:** W 0x11223344 with wstrb=4'b0101 sent 3 cycles before AW to a register holding 0xAAAAAAAA → register becomes 0xAA22AA44. wready=0 while waiting for AW, bvalid only after AW.
- **Out of range:** write and read to BASE+NUM_REGS*4 → SLVERR on both. rdata=0. No `wr_pulse`. All registers unchanged.
- **Backpressure:** bready=0 and rready=0 held for 5 cycles → bvalid and rvalid stay high, payload stays stable, awready and arready stay 0. On release, each completes in 1 cycle.
- **Collision and mid-transaction reset:**
  - Read and write to index 1 on the same edge → read returns the old value; the next read returns the new value.
  - aresetn pulsed while bvalid=1 → bvalid drops immediately and all registers clear.
